// File: rtl/instr_stream_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
// master = stream producer / memory side, slave = the loader.
interface instr_stream_loader_if #(
   parameter int WORD_BYTES = 4,
   parameter int ADDR_W     = 8
);
   logic                    in_valid;
   logic [7:0]              in_data;
   logic                    in_ready;
   logic                    imem_we;
   logic [ADDR_W-1:0]       imem_addr;
   logic [8*WORD_BYTES-1:0] imem_wdata;

   modport master (
      output in_valid, in_data,
      input  in_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/instr_stream_loader.sv
// Packs an opcode+operand byte stream into words written to imem.
// Optional macro OPCODE_CHECK_EN drops words with unknown opcodes.
module instr_stream_loader #(
   parameter int WORD_BYTES = 4,
   parameter int ADDR_W     = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                finish,
   instr_stream_loader_if.slave bus,
   output logic [ADDR_W:0]     instr_count,
   output logic                busy,
   output logic                done,
   output logic                full,
   output logic                err_partial,
   output logic                err_opcode
);

   typedef enum logic [2:0] {
      S_IDLE, S_OPCODE, S_OPERAND, S_WRITE, S_FULL
   } state_t;

   localparam int OPW = 8*(WORD_BYTES-1);
   localparam int IW  = $clog2(WORD_BYTES);
   localparam logic [IW-1:0]     LAST_IDX = IW'(WORD_BYTES-2);
   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   state_t                  state;
   state_t                  state_nxt;
   logic [IW-1:0]           idx;
   logic [7:0]              opcode;
   logic [OPW-1:0]          ops;
   logic [OPW+7:0]          shifted;
   logic [ADDR_W-1:0]       addr;
   logic [8*WORD_BYTES-1:0] wdata;
   logic                    accept;
   logic                    last_op;
   logic                    word_ok;
   logic                    done_nxt;

   assign accept  = bus.in_valid & bus.in_ready;
   assign shifted = {ops, bus.in_data};
   assign last_op = (idx == LAST_IDX);

   assign bus.imem_addr  = addr;
   assign bus.imem_wdata = wdata;

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // next-state: start overrides everything, finish beats a byte
   always_comb begin
      state_nxt = state;
      if (start) begin
         state_nxt = S_OPCODE;
      end else begin
         unique case (state)
            S_IDLE:    state_nxt = S_IDLE;
            S_OPCODE: begin
               if (finish)      state_nxt = S_IDLE;
               else if (accept) state_nxt = S_OPERAND;
            end
            S_OPERAND: begin
               if (finish)                 state_nxt = S_IDLE;
               else if (accept && last_op) state_nxt = S_WRITE;
            end
            S_WRITE: begin
               if (finish)
                  state_nxt = S_IDLE;
               else if (word_ok && addr == ADDR_MAX)
                  state_nxt = S_FULL;
               else
                  state_nxt = S_OPCODE;
            end
            S_FULL:    state_nxt = S_FULL;
            default:   state_nxt = S_IDLE;
         endcase
      end
   end

   // state-decoded outputs
   always_comb begin
      bus.in_ready = (state == S_OPCODE) || (state == S_OPERAND);
      busy         = (state != S_IDLE) && (state != S_FULL);
      full         = (state == S_FULL);
      bus.imem_we  = (state == S_WRITE) && word_ok;
   end

   // a load ends via finish only from an active state
   always_comb begin
      done_nxt = !start && finish &&
                 ((state == S_OPCODE) ||
                  (state == S_OPERAND) ||
                  (state == S_WRITE));
   end

   // datapath: byte assembly, address and count
   always_ff @(posedge clk) begin
      if (rst) begin
         idx         <= '0;
         opcode      <= '0;
         ops         <= '0;
         addr        <= '0;
         wdata       <= '0;
         instr_count <= '0;
         err_partial <= 1'b0;
         done        <= 1'b0;
      end else begin
         done <= done_nxt;
         if (start) begin
            idx         <= '0;
            addr        <= '0;
            instr_count <= '0;
            err_partial <= 1'b0;
         end else begin
            unique case (state)
               S_OPCODE: begin
                  if (accept && !finish) begin
                     opcode <= bus.in_data;
                     idx    <= '0;
                  end
               end
               S_OPERAND: begin
                  if (finish) begin
                     err_partial <= 1'b1;
                  end else if (accept) begin
                     ops <= shifted[OPW-1:0];
                     idx <= idx + 1'b1;
                     if (last_op && word_ok)
                        wdata <= {opcode, shifted[OPW-1:0]};
                  end
               end
               S_WRITE: begin
                  if (word_ok) begin
                     instr_count <= instr_count + 1'b1;
                     if (addr != ADDR_MAX) addr <= addr + 1'b1;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

`ifdef OPCODE_CHECK_EN
   function automatic logic op_legal(input logic [7:0] b);
      return (b >= 8'h80 && b <= 8'h87) ||
             (b >= 8'h89 && b <= 8'h90) ||
             (b == 8'h9F) || (b == 8'hA0) ||
             (b == 8'hB0);
   endfunction

   // classify each opcode as it is accepted
   always_ff @(posedge clk) begin
      if (rst) begin
         word_ok    <= 1'b1;
         err_opcode <= 1'b0;
      end else if (start) begin
         word_ok    <= 1'b1;
         err_opcode <= 1'b0;
      end else if (state == S_OPCODE && accept && !finish) begin
         word_ok <= op_legal(bus.in_data);
         if (!op_legal(bus.in_data)) err_opcode <= 1'b1;
      end
   end
`else
   assign word_ok    = 1'b1;
   assign err_opcode = 1'b0;
`endif

endmodule

// File: doc/instr_stream_loader.md
# instr_stream_loader

Sequential instruction-word packer feeding the instruction memory of the complex-number core. It accepts a byte stream over a valid/ready handshake (opcode byte first, then operand bytes), assembles each group into one instruction word and writes it to sequential instruction-memory addresses. It is the producer side of the opcode set consumed by the control decoder, so it emits only opcodes that the decoder recognises.

## Interface
- WORD_BYTES, 4, bytes per instruction word (opcode + WORD_BYTES-1 operands); legal range 2..8
- ADDR_W, 8, instruction-memory address width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begin a load at address 0
- finish  in  1  single-cycle pulse; end the current load
- in_valid  in  1  byte available
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts a byte this cycle
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  8*WORD_BYTES  instruction word; opcode in the MSB byte, operands in descending byte order
- instr_count  out  ADDR_W+1  words written since the last start
- busy  out  1  state is not IDLE or FULL
- done  out  1  one-cycle pulse when a load ends via finish
- full  out  1  address space exhausted
- err_partial  out  1  sticky: finish arrived mid-word
- err_opcode  out  1  sticky: illegal opcode seen (only with checking compiled in)

## Operation
- States: IDLE, OPCODE, OPERAND, WRITE, FULL.
- A byte is accepted when in_valid and in_ready are both high. in_ready is high only in OPCODE and OPERAND and is driven directly by the state.
- IDLE: on start, clear the address counter, instr_count, err_partial and err_opcode, then enter OPCODE.
- OPCODE: on accept, latch the byte as the opcode, clear the byte index and enter OPERAND.
- OPERAND: on accept, store the byte at its operand position. After the (WORD_BYTES-1)th operand, enter WRITE.
- WRITE: imem_we=1 for exactly one cycle with the current address and word. Then increment the address and instr_count. If the address written was 2^ADDR_W-1, enter FULL; otherwise enter OPCODE.
- FULL: full=1 and in_ready=0. Only start leaves this state.
- finish in OPCODE: enter IDLE and pulse done.
- finish in OPERAND: discard the partial word, set err_partial, enter IDLE and pulse done.
- finish in WRITE: complete the write, then enter IDLE and pulse done one cycle later.
- finish in IDLE or FULL: ignored.
- start in any state: abort the current activity and restart from OPCODE at address 0. start has priority over finish and over a byte accept in the same cycle; that byte is not consumed.
- The address counter stays within 0..2^ADDR_W-1 and never wraps. instr_count can reach 2^ADDR_W.

## Timing
- Reset values: state IDLE; in_ready, imem_we, busy, done, full, err_partial, err_opcode all 0; imem_addr 0, imem_wdata 0, instr_count 0.
- rst mid-load: the next cycle shows reset values and no write occurs.
- Latency: imem_we is asserted in the cycle immediately after the last operand byte is accepted.
- Throughput: WORD_BYTES+1 cycles per word with a continuously valid stream. There is one bubble cycle per word, in WRITE.
- imem_addr and imem_wdata are registered and hold their value outside WRITE.
- done is registered and asserted in the cycle the state shows IDLE.

## Configuration
- OPCODE_CHECK_EN defined:
  - Legal opcodes are 0x80–0x87, 0x89–0x8F, 0x90, 0x9F, 0xA0, 0xB0.
  - An illegal opcode byte is still accepted and its operands are still consumed.
  - err_opcode is set, the word is not written (WRITE issues no imem_we), and the address and instr_count do not advance.
- Undefined: every opcode byte is written unchanged, and err_opcode is tied to 0.

## Test plan
- Reset, then start, then 8 bytes 0x80,0x01,0x02,0x03,0x83,0x04,0x05,0x06 with in_valid held high -> writes 0x80010203 at addr 0 and 0x83040506 at addr 1, each 1 cycle after its 4th byte; then finish -> done pulse, instr_count=2.
- in_valid toggling every other cycle -> same words and addresses; no byte duplicated or dropped.
- ADDR_W=2, stream 4 words -> last write at addr 3, then full=1 and in_ready=0; a 5th byte is not accepted; start -> full=0, next write at addr 0.
- Start, send 0xA0,0x11, then finish -> no write, err_partial=1, done=1; a subsequent start clears err_partial.
- With OPCODE_CHECK_EN: send word 0x88,0,0,0 then 0x90,0,0,7 -> err_opcode=1; only 0x90000007 is written, at addr 0. Without the macro -> both written, at addr 0 and 1.
- rst asserted in the cycle after the 3rd byte of a word -> no imem_we, and all outputs at reset values.
